// File: rtl/vga_timing_gen.sv
// Raster timing generator: sync, visible coordinates, blank and frame/line markers.
// Advances one pixel per pixelEn; every output is registered from the next counter state.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic       pixelClk,
  input  logic       reset,
  input  logic       pixelEn,
  output logic       hSync,
  output logic       vSync,
  output logic [9:0] pixelCnt,
  output logic [8:0] lineCnt,
  output logic       compBlank,
  output logic       frameStart,
  output logic       lineEnd
);

  typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} phase_t;

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic H_ON = 1'(H_POL);
  localparam logic V_ON = 1'(V_POL);

  if (H_ACTIVE < 1 || H_SYNC < 1 || V_ACTIVE < 1 || V_SYNC < 1) begin : g_bad_params
    $error("vga_timing_gen: active and sync lengths must be at least 1");
  end

  // Zero-length porches are skipped when leaving the preceding phase.
  function automatic phase_t next_phase(input phase_t p, input int front, input int back);
    case (p)
      ACTIVE:  next_phase = (front > 0) ? FRONT : SYNC;
      FRONT:   next_phase = SYNC;
      SYNC:    next_phase = (back > 0) ? BACK : ACTIVE;
      default: next_phase = ACTIVE;
    endcase
  endfunction

  function automatic logic [10:0] phase_last(input phase_t p, input int act, input int front,
                                             input int sync, input int back);
    int len;
    len = act;
    case (p)
      ACTIVE:  len = act;
      FRONT:   len = front;
      SYNC:    len = sync;
      default: len = back;
    endcase
    phase_last = 11'(len - 1);
  endfunction

  phase_t      h_state_q, h_state_d, v_state_q, v_state_d;
  logic [10:0] h_left_q, h_left_d, v_left_q, v_left_d;
  logic [10:0] hCount_q, hCount_d, vCount_q, vCount_d;
  logic        hSync_q, hSync_d, vSync_q, vSync_d;
  logic [9:0]  pixelCnt_q, pixelCnt_d;
  logic [8:0]  lineCnt_q, lineCnt_d;
  logic        compBlank_q, compBlank_d, frameStart_q, frameStart_d, lineEnd_q, lineEnd_d;

  always_comb begin
    h_state_d    = h_state_q;
    v_state_d    = v_state_q;
    h_left_d     = h_left_q;
    v_left_d     = v_left_q;
    hCount_d     = hCount_q;
    vCount_d     = vCount_q;
    hSync_d      = hSync_q;
    vSync_d      = vSync_q;
    pixelCnt_d   = pixelCnt_q;
    lineCnt_d    = lineCnt_q;
    compBlank_d  = compBlank_q;
    frameStart_d = frameStart_q;
    lineEnd_d    = lineEnd_q;
    if (pixelEn) begin
      hCount_d = (hCount_q == H_LAST) ? 11'd0 : hCount_q + 11'd1;
      if (h_left_q == 11'd0) begin
        h_state_d = next_phase(h_state_q, H_FRONT, H_BACK);
        h_left_d  = phase_last(h_state_d, H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
      end else begin
        h_left_d = h_left_q - 11'd1;
      end
      // lineEnd_q marks the last pixel, so this step is the horizontal wrap.
      if (lineEnd_q) begin
        vCount_d = (vCount_q == V_LAST) ? 11'd0 : vCount_q + 11'd1;
        if (v_left_q == 11'd0) begin
          v_state_d = next_phase(v_state_q, V_FRONT, V_BACK);
          v_left_d  = phase_last(v_state_d, V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
        end else begin
          v_left_d = v_left_q - 11'd1;
        end
      end
      hSync_d      = (h_state_d == SYNC) ? H_ON : ~H_ON;
      vSync_d      = (v_state_d == SYNC) ? V_ON : ~V_ON;
      pixelCnt_d   = (h_state_d == ACTIVE) ? hCount_d[9:0] : 10'd0;
      lineCnt_d    = (v_state_d == ACTIVE) ? vCount_d[8:0] : 9'd0;
      compBlank_d  = (h_state_d != ACTIVE) || (v_state_d != ACTIVE);
      frameStart_d = (hCount_d == 11'd0) && (vCount_d == 11'd0);
      lineEnd_d    = (hCount_d == H_LAST);
    end
  end

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      h_state_q    <= ACTIVE;
      v_state_q    <= ACTIVE;
      h_left_q     <= phase_last(ACTIVE, H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
      v_left_q     <= phase_last(ACTIVE, V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
      hCount_q     <= 11'd0;
      vCount_q     <= 11'd0;
      hSync_q      <= ~H_ON;
      vSync_q      <= ~V_ON;
      pixelCnt_q   <= 10'd0;
      lineCnt_q    <= 9'd0;
      compBlank_q  <= 1'b0;
      frameStart_q <= 1'b0;
      lineEnd_q    <= 1'b0;
    end else begin
      h_state_q    <= h_state_d;
      v_state_q    <= v_state_d;
      h_left_q     <= h_left_d;
      v_left_q     <= v_left_d;
      hCount_q     <= hCount_d;
      vCount_q     <= vCount_d;
      hSync_q      <= hSync_d;
      vSync_q      <= vSync_d;
      pixelCnt_q   <= pixelCnt_d;
      lineCnt_q    <= lineCnt_d;
      compBlank_q  <= compBlank_d;
      frameStart_q <= frameStart_d;
      lineEnd_q    <= lineEnd_d;
    end
  end

  assign hSync      = hSync_q;
  assign vSync      = vSync_q;
  assign pixelCnt   = pixelCnt_q;
  assign lineCnt    = lineCnt_q;
  assign compBlank  = compBlank_q;
  assign frameStart = frameStart_q;
  assign lineEnd    = lineEnd_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets checked every clock against a
// position-based raster model (default 640x480, tiny with zero V porch, tiny positive-sync).
module tb_vga_timing_gen;

  localparam int N = 3;
  localparam int P_HA[N] = '{640, 4, 5};
  localparam int P_HF[N] = '{16, 1, 0};
  localparam int P_HS[N] = '{96, 2, 3};
  localparam int P_HB[N] = '{48, 1, 0};
  localparam int P_VA[N] = '{480, 3, 2};
  localparam int P_VF[N] = '{10, 0, 1};
  localparam int P_VS[N] = '{2, 1, 1};
  localparam int P_VB[N] = '{33, 1, 0};
  localparam int P_HP[N] = '{0, 0, 1};
  localparam int P_VP[N] = '{0, 0, 1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic       hs[N], vs[N], cb[N], fs[N], le[N];
  logic [9:0] pc[N];
  logic [8:0] lc[N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    vga_timing_gen #(
      .H_ACTIVE(P_HA[g]), .H_FRONT(P_HF[g]), .H_SYNC(P_HS[g]), .H_BACK(P_HB[g]),
      .V_ACTIVE(P_VA[g]), .V_FRONT(P_VF[g]), .V_SYNC(P_VS[g]), .V_BACK(P_VB[g]),
      .H_POL(P_HP[g]), .V_POL(P_VP[g])
    ) u_dut (
      .pixelClk(clk), .reset(rst), .pixelEn(en),
      .hSync(hs[g]), .vSync(vs[g]), .pixelCnt(pc[g]), .lineCnt(lc[g]),
      .compBlank(cb[g]), .frameStart(fs[g]), .lineEnd(le[g])
    );
  end

  int errors = 0;
  int checks = 0;
  int mh[N], mv[N];
  bit mfs[N];
  int fs_seen;

  task automatic chk(input string tag, input int idx, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d (h=%0d v=%0d)", tag, idx, obs, exp,
             mh[idx], mv[idx]);
    end
  endtask

  // Expected outputs follow purely from the raster position of each instance.
  task automatic compare_all();
    for (int i = 0; i < N; i++) begin
      int ht, hs0, vs0;
      bit hin, vin;
      ht  = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
      hs0 = P_HA[i] + P_HF[i];
      vs0 = P_VA[i] + P_VF[i];
      hin = (mh[i] >= hs0) && (mh[i] < hs0 + P_HS[i]);
      vin = (mv[i] >= vs0) && (mv[i] < vs0 + P_VS[i]);
      chk("hSync", i, int'(hs[i]), hin ? P_HP[i] : 1 - P_HP[i]);
      chk("vSync", i, int'(vs[i]), vin ? P_VP[i] : 1 - P_VP[i]);
      chk("pixelCnt", i, int'(pc[i]), (mh[i] < P_HA[i]) ? mh[i] : 0);
      chk("lineCnt", i, int'(lc[i]), (mv[i] < P_VA[i]) ? mv[i] : 0);
      chk("compBlank", i, int'(cb[i]), ((mh[i] >= P_HA[i]) || (mv[i] >= P_VA[i])) ? 1 : 0);
      chk("frameStart", i, int'(fs[i]), int'(mfs[i]));
      chk("lineEnd", i, int'(le[i]), (mh[i] == ht - 1) ? 1 : 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      int ht, vt;
      ht = P_HA[i] + P_HF[i] + P_HS[i] + P_HB[i];
      vt = P_VA[i] + P_VF[i] + P_VS[i] + P_VB[i];
      if (rst) begin
        mh[i] = 0; mv[i] = 0; mfs[i] = 1'b0;
      end else if (en) begin
        if (mh[i] == ht - 1) begin
          mh[i] = 0;
          mv[i] = (mv[i] == vt - 1) ? 0 : mv[i] + 1;
        end else begin
          mh[i] = mh[i] + 1;
        end
        mfs[i] = (mh[i] == 0) && (mv[i] == 0);
      end
    end
    #1;
    if (fs[1]) fs_seen++;
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin mh[i] = 0; mv[i] = 0; mfs[i] = 1'b0; end
    fs_seen = 0;

    // Reset state.
    rst = 1'b1; en = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // One full default line with the enable held high.
    for (int c = 0; c < 800; c++) tick();
    chk("line_wrap_h", 0, mh[0], 0);

    // Enable toggling every clock: outputs hold on the idle clocks.
    for (int c = 0; c < 1600; c++) begin
      en = (c % 2 == 0);
      tick();
    end

    // Random enable with rare resets, including resets while disabled.
    for (int c = 0; c < 40000; c++) begin
      en  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 1999) == 0);
      tick();
    end
    rst = 1'b0;

    // Walk the tiny instance into both syncs, then reset for a single cycle.
    begin
      int budget;
      bit found;
      budget = 200;
      found = 1'b0;
      en = 1'b1;
      while (budget > 0 && !found) begin
        tick();
        budget--;
        found = (mh[1] == 5) && (mv[1] == 3);
      end
      chk("reach_sync_timeout", 1, int'(found), 1);
      chk("in_sync_h", 1, int'(hs[1]), 0);
      chk("in_sync_v", 1, int'(vs[1]), 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_hSync", 1, int'(hs[1]), 1);
      chk("rst_vSync", 1, int'(vs[1]), 1);
      chk("rst_frameStart", 1, int'(fs[1]), 0);
    end

    // Exactly one frameStart across one tiny frame (8 pixels x 5 lines).
    fs_seen = 0;
    en = 1'b1;
    for (int c = 0; c < 40; c++) tick();
    chk("frameStart_count", 1, fs_seen, 1);
    chk("frame_wrap_pos", 1, mh[1] + mv[1], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
